// File: rtl/botao_debounce.sv
// Multi-channel push-button conditioner: synchroniser, debounce filter,
// and registered press / release / long-press one-cycle pulses.
module botao_debounce #(
    parameter int N_CANAIS     = 4,
    parameter int DEB_CICLOS   = 500000,
    parameter int LONGO_CICLOS = 50000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_CANAIS-1:0] botoes,
    input  logic                habilita,
    output logic [N_CANAIS-1:0] estado,
    output logic [N_CANAIS-1:0] pulso,
    output logic [N_CANAIS-1:0] solto,
    output logic [N_CANAIS-1:0] longo
);

    localparam int DW = (DEB_CICLOS > 1) ? $clog2(DEB_CICLOS) : 1;
    localparam int LW = (LONGO_CICLOS > 1) ? $clog2(LONGO_CICLOS) : 1;
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CICLOS - 1);
    localparam logic [LW-1:0] LONGO_MAX = LW'(LONGO_CICLOS - 1);

    logic [N_CANAIS-1:0] sync1;
    logic [N_CANAIS-1:0] s;
    logic [N_CANAIS-1:0] fired;
    logic [N_CANAIS-1:0] deb_done;
    logic [N_CANAIS-1:0] hold_done;
    logic [DW-1:0]       deb_cnt  [N_CANAIS];
    logic [LW-1:0]       hold_cnt [N_CANAIS];

    always_comb begin
        deb_done  = '0;
        hold_done = '0;
        for (int i = 0; i < N_CANAIS; i++) begin
            deb_done[i]  = (s[i] != estado[i]) && (deb_cnt[i] == DEB_MAX);
            hold_done[i] = estado[i] && !fired[i] && (hold_cnt[i] == LONGO_MAX);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= '0;
            s      <= '0;
            fired  <= '0;
            estado <= '0;
            pulso  <= '0;
            solto  <= '0;
            longo  <= '0;
            for (int i = 0; i < N_CANAIS; i++) begin
                deb_cnt[i]  <= '0;
                hold_cnt[i] <= '0;
            end
        end else begin
            sync1 <= botoes;
            s     <= sync1;
            pulso <= {N_CANAIS{habilita}} & deb_done & s;
            solto <= {N_CANAIS{habilita}} & deb_done & ~s;
            longo <= {N_CANAIS{habilita}} & hold_done;
            for (int i = 0; i < N_CANAIS; i++) begin
                if (s[i] == estado[i] || deb_done[i]) begin
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
                if (deb_done[i]) begin
                    estado[i] <= s[i];
                end
                // hold counter parks once fired so longo fires once per press
                if (!estado[i]) begin
                    hold_cnt[i] <= '0;
                    fired[i]    <= 1'b0;
                end else if (hold_done[i]) begin
                    fired[i] <= 1'b1;
                end else if (!fired[i]) begin
                    hold_cnt[i] <= hold_cnt[i] + LW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_botao_debounce.sv
// Scoreboard bench for botao_debounce with DEB_CICLOS=4, LONGO_CICLOS=10.
module tb_botao_debounce;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] botoes;
    logic       habilita;
    logic [3:0] estado, pulso, solto, longo;

    botao_debounce #(
        .N_CANAIS(4),
        .DEB_CICLOS(4),
        .LONGO_CICLOS(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .botoes(botoes),
        .habilita(habilita),
        .estado(estado),
        .pulso(pulso),
        .solto(solto),
        .longo(longo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int         e;
        logic [3:0] est;
        logic [3:0] pul;
        logic [3:0] sol;
        logic [3:0] lon;
    } exp_t;

    exp_t sb[$];
    exp_t x;
    int   checks = 0;
    int   errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        habilita = 1'b1;
        botoes   = 4'b1111;
        tick();
        tick();
        checks++;
        if ({estado, pulso, solto, longo} !== 16'h0) begin
            errors++;
            $display("FAIL reset got=%h exp=0000", {estado, pulso, solto, longo});
        end
        botoes = 4'b0000;
        tick();
        reset = 1'b0;
        for (int e = 0; e < 8; e++) tick();
        checks++;
        if ({estado, pulso, solto, longo} !== 16'h0) begin
            errors++;
            $display("FAIL reset_rel got=%h exp=0000", {estado, pulso, solto, longo});
        end
    endtask

    task automatic test_press();
        botoes = 4'b0001;
        sb.push_back('{5, 4'b0001, 4'b0001, 4'b0000, 4'b0000});
        sb.push_back('{6, 4'b0001, 4'b0000, 4'b0000, 4'b0000});
        for (int e = 0; e <= 6; e++) begin
            tick();
            if (sb.size() > 0 && sb[0].e == e) begin
                x = sb.pop_front();
                checks++;
                if ({estado, pulso, solto, longo} !== {x.est, x.pul, x.sol, x.lon}) begin
                    errors++;
                    $display("FAIL press e=%0d got=%h exp=%h", e,
                             {estado, pulso, solto, longo}, {x.est, x.pul, x.sol, x.lon});
                end
            end else begin
                checks++;
                if ({pulso, solto, longo} !== 12'h0) begin
                    errors++;
                    $display("FAIL press_idle e=%0d got=%h exp=000", e, {pulso, solto, longo});
                end
            end
        end
        // release before the long-press point: solto only, never longo
        botoes = 4'b0000;
        sb.push_back('{5, 4'b0000, 4'b0000, 4'b0001, 4'b0000});
        for (int e = 0; e <= 14; e++) begin
            tick();
            if (sb.size() > 0 && sb[0].e == e) begin
                x = sb.pop_front();
                checks++;
                if ({estado, pulso, solto, longo} !== {x.est, x.pul, x.sol, x.lon}) begin
                    errors++;
                    $display("FAIL short_rel e=%0d got=%h exp=%h", e,
                             {estado, pulso, solto, longo}, {x.est, x.pul, x.sol, x.lon});
                end
            end else begin
                checks++;
                if ({pulso, solto, longo} !== 12'h0) begin
                    errors++;
                    $display("FAIL short_rel_idle e=%0d got=%h exp=000", e, {pulso, solto, longo});
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL press_left got=%0d exp=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_glitch();
        botoes = 4'b0010;
        sb.push_back('{4, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        sb.push_back('{10, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        for (int e = 0; e <= 10; e++) begin
            tick();
            if (e == 2) botoes = 4'b0000;
            if (sb.size() > 0 && sb[0].e == e) begin
                x = sb.pop_front();
                checks++;
                if ({estado, pulso, solto, longo} !== {x.est, x.pul, x.sol, x.lon}) begin
                    errors++;
                    $display("FAIL glitch e=%0d got=%h exp=%h", e,
                             {estado, pulso, solto, longo}, {x.est, x.pul, x.sol, x.lon});
                end
            end else begin
                checks++;
                if ({estado, pulso, solto, longo} !== 16'h0) begin
                    errors++;
                    $display("FAIL glitch_idle e=%0d got=%h exp=0000", e,
                             {estado, pulso, solto, longo});
                end
            end
        end
    endtask

    task automatic test_long();
        botoes = 4'b0100;
        sb.push_back('{5, 4'b0100, 4'b0100, 4'b0000, 4'b0000});
        sb.push_back('{15, 4'b0100, 4'b0000, 4'b0000, 4'b0100});
        sb.push_back('{16, 4'b0100, 4'b0000, 4'b0000, 4'b0000});
        for (int e = 0; e <= 30; e++) begin
            tick();
            if (sb.size() > 0 && sb[0].e == e) begin
                x = sb.pop_front();
                checks++;
                if ({estado, pulso, solto, longo} !== {x.est, x.pul, x.sol, x.lon}) begin
                    errors++;
                    $display("FAIL long e=%0d got=%h exp=%h", e,
                             {estado, pulso, solto, longo}, {x.est, x.pul, x.sol, x.lon});
                end
            end else begin
                checks++;
                if ({pulso, solto, longo} !== 12'h0) begin
                    errors++;
                    $display("FAIL long_idle e=%0d got=%h exp=000", e, {pulso, solto, longo});
                end
            end
        end
        botoes = 4'b0000;
        sb.push_back('{5, 4'b0000, 4'b0000, 4'b0100, 4'b0000});
        for (int e = 0; e <= 8; e++) begin
            tick();
            if (sb.size() > 0 && sb[0].e == e) begin
                x = sb.pop_front();
                checks++;
                if ({estado, pulso, solto, longo} !== {x.est, x.pul, x.sol, x.lon}) begin
                    errors++;
                    $display("FAIL long_rel e=%0d got=%h exp=%h", e,
                             {estado, pulso, solto, longo}, {x.est, x.pul, x.sol, x.lon});
                end
            end else begin
                checks++;
                if ({pulso, solto, longo} !== 12'h0) begin
                    errors++;
                    $display("FAIL long_rel_idle e=%0d got=%h exp=000", e, {pulso, solto, longo});
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL long_left got=%0d exp=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_enable();
        habilita = 1'b0;
        botoes   = 4'b1000;
        // press is swallowed; the hold counter keeps running regardless
        sb.push_back('{5, 4'b1000, 4'b0000, 4'b0000, 4'b0000});
        sb.push_back('{15, 4'b1000, 4'b0000, 4'b0000, 4'b1000});
        for (int e = 0; e <= 18; e++) begin
            tick();
            if (e == 8) habilita = 1'b1;
            if (sb.size() > 0 && sb[0].e == e) begin
                x = sb.pop_front();
                checks++;
                if ({estado, pulso, solto, longo} !== {x.est, x.pul, x.sol, x.lon}) begin
                    errors++;
                    $display("FAIL enable e=%0d got=%h exp=%h", e,
                             {estado, pulso, solto, longo}, {x.est, x.pul, x.sol, x.lon});
                end
            end else begin
                checks++;
                if ({pulso, solto, longo} !== 12'h0) begin
                    errors++;
                    $display("FAIL enable_idle e=%0d got=%h exp=000", e, {pulso, solto, longo});
                end
            end
        end
        habilita = 1'b0;
        botoes   = 4'b0000;
        sb.push_back('{5, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        for (int e = 0; e <= 9; e++) begin
            tick();
            if (e == 7) habilita = 1'b1;
            if (sb.size() > 0 && sb[0].e == e) begin
                x = sb.pop_front();
                checks++;
                if ({estado, pulso, solto, longo} !== {x.est, x.pul, x.sol, x.lon}) begin
                    errors++;
                    $display("FAIL enable_rel e=%0d got=%h exp=%h", e,
                             {estado, pulso, solto, longo}, {x.est, x.pul, x.sol, x.lon});
                end
            end else begin
                checks++;
                if ({pulso, solto, longo} !== 12'h0) begin
                    errors++;
                    $display("FAIL enable_rel_idle e=%0d got=%h exp=000", e, {pulso, solto, longo});
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        botoes = 4'b1111;
        sb.push_back('{5, 4'b1111, 4'b1111, 4'b0000, 4'b0000});
        sb.push_back('{15, 4'b1111, 4'b0000, 4'b0000, 4'b1111});
        for (int e = 0; e <= 16; e++) begin
            tick();
            if (sb.size() > 0 && sb[0].e == e) begin
                x = sb.pop_front();
                checks++;
                if ({estado, pulso, solto, longo} !== {x.est, x.pul, x.sol, x.lon}) begin
                    errors++;
                    $display("FAIL all4 e=%0d got=%h exp=%h", e,
                             {estado, pulso, solto, longo}, {x.est, x.pul, x.sol, x.lon});
                end
            end else begin
                checks++;
                if ({pulso, solto, longo} !== 12'h0) begin
                    errors++;
                    $display("FAIL all4_idle e=%0d got=%h exp=000", e, {pulso, solto, longo});
                end
            end
        end
        botoes = 4'b0000;
        sb.push_back('{5, 4'b0000, 4'b0000, 4'b1111, 4'b0000});
        for (int e = 0; e <= 7; e++) begin
            tick();
            if (sb.size() > 0 && sb[0].e == e) begin
                x = sb.pop_front();
                checks++;
                if ({estado, pulso, solto, longo} !== {x.est, x.pul, x.sol, x.lon}) begin
                    errors++;
                    $display("FAIL all4_rel e=%0d got=%h exp=%h", e,
                             {estado, pulso, solto, longo}, {x.est, x.pul, x.sol, x.lon});
                end
            end else begin
                checks++;
                if ({pulso, solto, longo} !== 12'h0) begin
                    errors++;
                    $display("FAIL all4_rel_idle e=%0d got=%h exp=000", e, {pulso, solto, longo});
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        botoes = 4'b0001;
        for (int e = 0; e <= 3; e++) tick();
        reset = 1'b1;
        #1;
        checks++;
        if ({estado, pulso, solto, longo} !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid got=%h exp=0000", {estado, pulso, solto, longo});
        end
        tick();
        reset = 1'b0;
        sb.push_back('{4, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        sb.push_back('{5, 4'b0001, 4'b0001, 4'b0000, 4'b0000});
        for (int e = 0; e <= 6; e++) begin
            tick();
            if (sb.size() > 0 && sb[0].e == e) begin
                x = sb.pop_front();
                checks++;
                if ({estado, pulso, solto, longo} !== {x.est, x.pul, x.sol, x.lon}) begin
                    errors++;
                    $display("FAIL reset_mid_req e=%0d got=%h exp=%h", e,
                             {estado, pulso, solto, longo}, {x.est, x.pul, x.sol, x.lon});
                end
            end else begin
                checks++;
                if ({pulso, solto, longo} !== 12'h0) begin
                    errors++;
                    $display("FAIL reset_mid_idle e=%0d got=%h exp=000", e, {pulso, solto, longo});
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_left got=%0d exp=0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_long();
        test_enable();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/botao_debounce.md
BOTAO_DEBOUNCE -- requirements
Module: botao_debounce

Interface
REQ-001 The block SHALL have parameter N_CANAIS, default 4, giving the number of independent button channels (minimum 1).
REQ-002 The block SHALL have parameter DEB_CICLOS, default 500000, giving the number of consecutive clock cycles a synchronised input must differ from the stable state before being accepted (minimum 1).
REQ-003 The block SHALL have parameter LONGO_CICLOS, default 50000000, giving the number of cycles after a press pulse at which the long-press pulse fires (minimum 2).
REQ-004 The block SHALL have port clk, input, 1, rising-edge system clock.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port botoes, input, N_CANAIS, raw asynchronous button levels (1 = pressed).
REQ-007 The block SHALL have port habilita, input, 1, global event enable (0 = pulses suppressed).
REQ-008 The block SHALL have port estado, output, N_CANAIS, debounced level per channel.
REQ-009 The block SHALL have port pulso, output, N_CANAIS, one-cycle press pulse per channel.
REQ-010 The block SHALL have port solto, output, N_CANAIS, one-cycle release pulse per channel.
REQ-011 The block SHALL have port longo, output, N_CANAIS, one-cycle long-press pulse per channel.

Function
REQ-012 Each channel SHALL pass botoes[i] through a two-flop synchroniser; the second flop output is the synchronised level s[i].
REQ-013 Each channel SHALL keep a debounce counter of width clog2(DEB_CICLOS) (minimum 1 bit); the counter clears to 0 on any cycle where s[i] equals estado[i].
REQ-014 While s[i] differs from estado[i], the counter SHALL increment; on the edge where it equals DEB_CICLOS-1, estado[i] SHALL take s[i] and the counter SHALL clear.
REQ-015 Latency: a clean level change present before clock edge 0 SHALL appear on estado[i] after edge DEB_CICLOS+1.
REQ-016 Any input excursion shorter than DEB_CICLOS synchronised cycles SHALL leave estado[i] unchanged and produce no pulse.
REQ-017 pulso[i] SHALL be high for exactly the one cycle in which estado[i] transitions 0->1, gated by habilita sampled on that same edge.
REQ-018 solto[i] SHALL be high for exactly the one cycle in which estado[i] transitions 1->0, gated by habilita sampled on that same edge.
REQ-019 Each channel SHALL keep a hold counter of width clog2(LONGO_CICLOS) and a "fired" flag; both clear while estado[i]=0.
REQ-020 While estado[i]=1 and fired=0, the hold counter SHALL increment; on the edge where it equals LONGO_CICLOS-1, longo[i] SHALL pulse for one cycle (gated by habilita) and fired SHALL set.
REQ-021 longo[i] SHALL assert exactly LONGO_CICLOS cycles after the pulso[i] cycle, at most once per press, and never if release occurs first.
REQ-022 With habilita=0, estado and all counters SHALL keep operating; only pulso, solto and longo are forced to 0. Suppressed events SHALL NOT be replayed later.
REQ-023 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 While reset=1, all synchroniser flops, counters, fired flags, estado, pulso, solto and longo SHALL be 0.
REQ-026 Assertion of reset mid-debounce or mid-hold SHALL discard the partial count; after release, a button held high SHALL be re-qualified from zero, with pulso after DEB_CICLOS+1 edges.
REQ-027 No pulse SHALL be generated by the release of reset itself unless the input remains high for the full debounce time.

Verification (DEB_CICLOS=4, LONGO_CICLOS=10, N_CANAIS=4)
REQ-028 Scenario: botoes=0001 before edge 0 and held -> estado[0]=1 and pulso=0001 after edge 5; pulso=0000 after edge 6.
REQ-029 Scenario: botoes[1] high for 3 cycles, then low -> estado[1] stays 0; pulso, solto and longo stay 0.
REQ-030 Scenario: channel 2 held -> longo=0100 exactly 10 cycles after its pulso cycle, once only; release -> solto=0100 after 5 edges.
REQ-031 Scenario: channel 3 pressed with habilita=0 across the transition -> estado[3]=1, with pulso[3] never asserted; habilita=1 later -> still no pulse.
REQ-032 Scenario: botoes=1111 simultaneously -> pulso=1111 in a single cycle.
REQ-033 Scenario: reset asserted at debounce count 2 while held -> all outputs 0 at once; after release, pulso asserts 5 edges later.
